bitwise_and: RTL and testbench
==============================

// Module: bitwise_and
// PURPOSE
// - Registered 16-bit (parameterisable) bitwise AND unit for the ALU datapath.
// - Computes out = A & B one clock after the operands are presented.
// - Also provides a zero flag and a population count of the result for
//   condition-code and test logic.
// - Single clock domain, synchronous active-high reset.
// PARAMETERS
// - WIDTH  16  operand/result width in bits (>=1)
// - CNT_W  $clog2(WIDTH+1)  width of popcount output (5 for WIDTH=16)
// PORTS
// - clk        in   1       clock, all state updates on rising edge
// - rst        in   1       synchronous reset, active-high
// - in_valid   in   1       A/B are valid this cycle
// - A          in   WIDTH   operand A
// - B          in   WIDTH   operand B
// - out        out  WIDTH   registered A & B
// - out_valid  out  1       out/zero/ones hold a fresh result this cycle
// - zero       out  1       1 when out == 0 (qualified by out_valid)
// - ones       out  CNT_W   number of set bits in out
// BEHAVIOUR
// - Reset: on a rising clk edge with rst=1: out=0, out_valid=0, zero=1, ones=0.
//   rst has priority over in_valid on the same edge.
// - Latency 1 cycle: if in_valid=1 at edge N (rst=0), then after edge N
//   out=A&B, zero=~|(A&B), ones=popcount(A&B), out_valid=1.
// - If in_valid=0 at an edge: out/zero/ones hold their previous values,
//   out_valid=0. No backpressure; a new result is accepted every cycle.
// - Back-to-back valid inputs produce back-to-back valid results, in order.
// - Per-bit: out[i] = A[i] & B[i]; no carries, no sign handling.
// - zero and ones are computed from the registered out (or equivalently from
//   A&B before the register) so all three outputs are always consistent.
// - X on A/B with in_valid=0 must not propagate to the outputs.
// - Reset asserted mid-stream discards any pending result; first valid output
//   after rst deasserts comes 1 cycle after the first accepted in_valid.
// TESTING
// - Reset: hold rst=1 for 2 cycles with in_valid=1, A=B=16'hFFFF
//   -> out=0, out_valid=0, zero=1, ones=0.
// - A=16'h0000, B=16'h0000, in_valid=1 -> next cycle out=16'h0000,
//   zero=1, ones=0, out_valid=1.
// - A=16'h0666, B=16'h3080, in_valid=1 -> next cycle out=16'h0000, zero=1, ones=0.
// - A=16'h8666, B=16'hB406, in_valid=1 -> next cycle out=16'h8406, zero=0, ones=4.
// - A=16'hFFFF, B=16'hFFFF then in_valid=0 for 3 cycles -> out=16'hFFFF,
//   ones=16, out_valid high one cycle only, values held afterwards.
// - Random A/B streamed every cycle with rst pulsed mid-stream -> out matches
//   A&B of the previous cycle, out_valid=0 the cycle after rst.

Source files
------------

// File: rtl/bitwise_and.sv
// Registered bitwise AND for the ALU datapath, with a zero flag and a popcount
// of the result that always stay consistent with the registered output.
module bitwise_and #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             zero,
    output logic [CNT_W-1:0] ones
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [WIDTH-1:0] and_res;
    logic [CNT_W-1:0] and_cnt;

    // Flags come from the same AND result that is registered, so all three
    // outputs describe the same value in the same cycle.
    always_comb begin
        and_res = A & B;
        and_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            and_cnt = and_cnt + CNT_W'(and_res[i]);
        end
    end

    // Operands are only looked at when valid, so X on idle inputs never leaks.
    always_comb begin
        out_d       = out_q;
        zero_d      = zero_q;
        ones_d      = ones_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = and_res;
            zero_d      = ~|and_res;
            ones_d      = and_cnt;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            ones_q      <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            zero_q      <= zero_d;
            ones_q      <= ones_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign zero      = zero_q;
    assign ones      = ones_q;

endmodule

// File: tb/tb_bitwise_and.sv
// Self-checking bench for bitwise_and: directed cases followed by a random
// stream with a mid-stream reset, compared against a behavioural model.
module tb_bitwise_and;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             zero;
    logic [CNT_W-1:0] ones;

    logic [WIDTH-1:0] exp_out;
    logic             exp_valid;
    logic             exp_zero;
    logic [CNT_W-1:0] exp_ones;

    int vectors;
    int miscompares;

    bitwise_and #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a_in),
        .B         (b_in),
        .out       (out),
        .out_valid (out_valid),
        .zero      (zero),
        .ones      (ones)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic applyStimulus(input logic r, input logic v,
                                 input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] prod;
        rst      = r;
        in_valid = v;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
        if (r) begin
            exp_out   = '0;
            exp_valid = 1'b0;
            exp_zero  = 1'b1;
            exp_ones  = '0;
        end else if (v) begin
            prod      = a & b;
            exp_out   = prod;
            exp_valid = 1'b1;
            exp_zero  = (prod == 0);
            exp_ones  = CNT_W'($countones(prod));
        end else begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic checkOutput(input string tag);
        vectors++;
        assert (out === exp_out) else begin
            miscompares++;
            $error("[TB] FAIL %s out observed=%h expected=%h", tag, out, exp_out);
        end
        vectors++;
        assert (out_valid === exp_valid) else begin
            miscompares++;
            $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_valid);
        end
        vectors++;
        assert (zero === exp_zero) else begin
            miscompares++;
            $error("[TB] FAIL %s zero observed=%b expected=%b", tag, zero, exp_zero);
        end
        vectors++;
        assert (ones === exp_ones) else begin
            miscompares++;
            $error("[TB] FAIL %s ones observed=%0d expected=%0d", tag, ones, exp_ones);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rv;
        logic             rr;

        vectors     = 0;
        miscompares = 0;
        exp_out     = '0;
        exp_valid   = 1'b0;
        exp_zero    = 1'b1;
        exp_ones    = '0;

        applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        checkOutput("reset1");
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        checkOutput("reset2");

        applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000);
        checkOutput("zero_ops");
        applyStimulus(1'b0, 1'b1, 16'h0666, 16'h3080);
        checkOutput("disjoint");
        applyStimulus(1'b0, 1'b1, 16'h8666, 16'hB406);
        checkOutput("pattern");
        if (out !== 16'h8406 || ones !== 5'd4) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL pattern_const out=%h ones=%0d required=8406/4", out, ones);
        end

        applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        checkOutput("all_ones");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 'x, 'x);
            checkOutput("hold_x");
        end

        applyStimulus(1'b0, 1'b1, 16'h1234, 16'hFFFF);
        checkOutput("pre_rst");
        applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        checkOutput("mid_rst");
        applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
        checkOutput("post_rst_idle");

        for (int i = 0; i < 200; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rv = ($urandom_range(0, 9) != 0);
            rr = (i == 100);
            applyStimulus(rr, rv, ra, rb);
            checkOutput(rr ? "rand_rst" : "rand");
        end

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
